// File: rtl/data_memory.sv
// Byte-addressable RV32 data memory with a valid/ready request port and a
// single-entry registered response. Loads and stores both complete with
// one cycle of latency. Illegal or misaligned requests answer with resp_err.
module data_memory #(
    parameter int MEM_SIZE  = 256,
    parameter int WORD_SIZE = 32,
    localparam int ADDR_W   = $clog2(MEM_SIZE) + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 resp_err
);

    localparam int IDX_W = ADDR_W - 2;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    logic [WORD_SIZE-1:0] mem [MEM_SIZE];

    funct3_e              f3;
    logic [IDX_W-1:0]     word_idx;
    logic [1:0]           offset;
    logic                 accept;
    logic                 op_ok;
    logic                 aligned;
    logic                 err;
    logic [3:0]           size_be;
    logic [3:0]           byte_en;
    logic [WORD_SIZE-1:0] lane_data;
    logic [WORD_SIZE-1:0] rd_word;
    logic [WORD_SIZE-1:0] shifted;
    logic [WORD_SIZE-1:0] load_val;

    assign f3        = funct3_e'(req_funct3);
    assign word_idx  = req_addr[ADDR_W-1:2];
    assign offset    = req_addr[1:0];
    // A new request fits whenever the response slot is empty or drains this cycle.
    assign req_ready = !resp_valid || resp_ready;
    assign accept    = req_valid && req_ready;

    // Decode width/sign code into legality, alignment and the base lane mask.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        op_ok   = 1'b0;
        aligned = 1'b0;
        size_be = 4'b0000;
        case (f3)
            F3_B:  begin op_ok = 1'b1;    aligned = 1'b1;          size_be = 4'b0001; end
            F3_H:  begin op_ok = 1'b1;    aligned = !offset[0];    size_be = 4'b0011; end
            F3_W:  begin op_ok = 1'b1;    aligned = (offset == 2'd0); size_be = 4'b1111; end
            F3_BU: begin op_ok = !req_we; aligned = 1'b1;          size_be = 4'b0001; end
            F3_HU: begin op_ok = !req_we; aligned = !offset[0];    size_be = 4'b0011; end
            default: begin op_ok = 1'b0;  aligned = 1'b0;          size_be = 4'b0000; end
        endcase
        err       = !(op_ok && aligned);
        byte_en   = size_be << offset;
        lane_data = req_wdata << {offset, 3'b000};
    end

    // Read the addressed word, shift the lanes down and extend to full width.
    always_comb begin
        rd_word  = mem[word_idx];
        shifted  = rd_word >> {offset, 3'b000};
        load_val = '0;
        case (f3)
            F3_B:    load_val = {{24{shifted[7]}},  shifted[7:0]};
            F3_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_val = {24'd0, shifted[7:0]};
            F3_HU:   load_val = {16'd0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // Storage: reset clears every word; a legal store updates only its lanes.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the array is made of flops with an async clear because reset
        // must read back all-zero; that rules out mapping it onto a RAM macro.
        if (rst) begin
            mem <= '{default: '0};
        end else if (accept && req_we && !err) begin
            for (int b = 0; b < 4; b++) begin
                // NOTE: state is always updated with <= so every flop samples
                // the pre-edge values regardless of statement order.
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

    // Response slot: capture on accept, hold under backpressure, clear on drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_rdata <= (req_we || err) ? '0 : load_val;
            resp_err   <= err;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: reset state, load extension, byte-lane
// stores, error cases, backpressure and asynchronous reset mid-stream.
module tb_data_memory;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    int checks = 0;
    int errors = 0;

    data_memory #(.MEM_SIZE(256), .WORD_SIZE(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present a request at the falling edge, let it be accepted at the next
    // rising edge, then check the response one step after that edge.
    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = 1'b1;
        #1 check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, ".valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, ".rdata"}, resp_rdata, exp_rdata);
        check({tag, ".err"},   {31'd0, resp_err}, {31'd0, exp_err});
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 check("idle.valid", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst.valid", {31'd0, resp_valid}, 32'd0);
        check("rst.rdata", resp_rdata, 32'd0);
        check("rst.err",   {31'd0, resp_err}, 32'd0);
        check("rst.ready", {31'd0, req_ready}, 32'd1);

        // First accept on the first rising edge after release: LW 0x10
        @(negedge clk);
        rst        = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 10'h010;
        @(posedge clk);
        #1;
        check("lw10.valid", {31'd0, resp_valid}, 32'd1);
        check("lw10.rdata", resp_rdata, 32'h0000_0000);
        check("lw10.err",   {31'd0, resp_err}, 32'd0);

        // Back-to-back store and extending loads
        txn("sw20",  1'b1, 3'b010, 10'h020, 32'h8081_F2A3, 32'h0000_0000, 1'b0);
        txn("lb20",  1'b0, 3'b000, 10'h020, 32'h0,         32'hFFFF_FFA3, 1'b0);
        txn("lbu21", 1'b0, 3'b100, 10'h021, 32'h0,         32'h0000_00F2, 1'b0);
        txn("lh22",  1'b0, 3'b001, 10'h022, 32'h0,         32'hFFFF_8081, 1'b0);
        txn("lhu22", 1'b0, 3'b101, 10'h022, 32'h0,         32'h0000_8081, 1'b0);

        // Byte and half stores touch only their lanes; load right after store
        txn("sb23",  1'b1, 3'b000, 10'h023, 32'h0000_005A, 32'h0000_0000, 1'b0);
        txn("lw20a", 1'b0, 3'b010, 10'h020, 32'h0,         32'h5A81_F2A3, 1'b0);
        txn("sh22",  1'b1, 3'b001, 10'h022, 32'h1234_BEEF, 32'h0000_0000, 1'b0);
        txn("lw20b", 1'b0, 3'b010, 10'h020, 32'h0,         32'hBEEF_F2A3, 1'b0);
        txn("lh20",  1'b0, 3'b001, 10'h020, 32'h0,         32'hFFFF_F2A3, 1'b0);

        // Illegal and misaligned requests
        txn("lh21",  1'b0, 3'b001, 10'h021, 32'h0,         32'h0000_0000, 1'b1);
        txn("sw22",  1'b1, 3'b010, 10'h022, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        txn("f3_011",1'b0, 3'b011, 10'h020, 32'h0,         32'h0000_0000, 1'b1);
        txn("sbu20", 1'b1, 3'b100, 10'h020, 32'h0000_0000, 32'h0000_0000, 1'b1);
        txn("sh21",  1'b1, 3'b001, 10'h021, 32'h0000_0000, 32'h0000_0000, 1'b1);
        txn("lw20c", 1'b0, 3'b010, 10'h020, 32'h0,         32'hBEEF_F2A3, 1'b0);

        // Neighbouring word and the top word of the array
        txn("sw24",  1'b1, 3'b010, 10'h024, 32'h1122_3344, 32'h0000_0000, 1'b0);
        txn("sw3fc", 1'b1, 3'b010, 10'h3FC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0);
        txn("lbu3ff",1'b0, 3'b100, 10'h3FF, 32'h0,         32'h0000_00CA, 1'b0);
        txn("lb3ff", 1'b0, 3'b000, 10'h3FF, 32'h0,         32'hFFFF_FFCA, 1'b0);
        txn("lw000", 1'b0, 3'b010, 10'h000, 32'h0,         32'h0000_0000, 1'b0);
        txn("lw20d", 1'b0, 3'b010, 10'h020, 32'h0,         32'hBEEF_F2A3, 1'b0);
        idle();

        // Backpressure: response A held for 3 cycles while request B waits
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 10'h024;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        check("bp.a_valid", {31'd0, resp_valid}, 32'd1);
        check("bp.a_rdata", resp_rdata, 32'h1122_3344);
        @(negedge clk);
        req_addr = 10'h3FC;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp.ready_low", {31'd0, req_ready}, 32'd0);
            @(posedge clk);
            #1;
            check("bp.hold_valid", {31'd0, resp_valid}, 32'd1);
            check("bp.hold_rdata", resp_rdata, 32'h1122_3344);
            check("bp.hold_err",   {31'd0, resp_err}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1 check("bp.ready_high", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("bp.b_valid", {31'd0, resp_valid}, 32'd1);
        check("bp.b_rdata", resp_rdata, 32'hCAFE_F00D);
        idle();

        // Asynchronous reset while a response is pending
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 10'h020;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        check("ar.pending", {31'd0, resp_valid}, 32'd1);
        check("ar.pend_rd", resp_rdata, 32'hBEEF_F2A3);
        #1 rst = 1'b1;
        #1;
        check("ar.valid", {31'd0, resp_valid}, 32'd0);
        check("ar.rdata", resp_rdata, 32'd0);
        check("ar.err",   {31'd0, resp_err}, 32'd0);
        check("ar.ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("ar.no_resp", {31'd0, resp_valid}, 32'd0);
        txn("ar.lw20",  1'b0, 3'b010, 10'h020, 32'h0, 32'h0000_0000, 1'b0);
        txn("ar.lw24",  1'b0, 3'b010, 10'h024, 32'h0, 32'h0000_0000, 1'b0);
        txn("ar.lw3fc", 1'b0, 3'b010, 10'h3FC, 32'h0, 32'h0000_0000, 1'b0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter MEM_SIZE, default 256, SHALL set the number of words; it SHALL be a power of two and at least 4.
REQ-002 Parameter WORD_SIZE, default 32, SHALL set the data width; only 32 is supported.
REQ-003 Derived ADDR_W = $clog2(MEM_SIZE)+2 SHALL be the byte-address width.
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-006 req_valid  in  1  SHALL flag a request present.
REQ-007 req_ready  out  1  SHALL flag that the block accepts a request this cycle.
REQ-008 req_we  in  1  SHALL select store (1) or load (0).
REQ-009 req_funct3  in  3  SHALL carry the RV32 width/sign code.
REQ-010 req_addr  in  ADDR_W  SHALL carry the byte address.
REQ-011 req_wdata  in  WORD_SIZE  SHALL carry store data, right-aligned.
REQ-012 resp_valid  out  1  SHALL flag a response present.
REQ-013 resp_ready  in  1  SHALL flag that the consumer takes the response.
REQ-014 resp_rdata  out  WORD_SIZE  SHALL carry the extended load data; 0 for stores and errors.
REQ-015 resp_err  out  1  SHALL flag an illegal or misaligned request.

Function
REQ-016 Accept SHALL occur when req_valid and req_ready are both high at a rising edge.
REQ-017 req_ready SHALL equal (!resp_valid || resp_ready), so at most one response is outstanding.
REQ-018 Every accepted request, load or store, SHALL produce exactly one response, with resp_valid high on the cycle after accept (latency 1).
REQ-019 resp_valid, resp_rdata and resp_err SHALL hold stable while resp_valid && !resp_ready.
REQ-020 Back-to-back requests SHALL sustain one accept per cycle when resp_ready stays high.
REQ-021 Word index SHALL be req_addr[ADDR_W-1:2]; byte offset SHALL be req_addr[1:0].
REQ-022 funct3 decoding: 000 byte, 001 half, 010 word, 100 byte unsigned (load only), 101 half unsigned (load only).
REQ-023 Any other funct3, or 100/101 with req_we=1, SHALL give resp_err=1 with no memory change.
REQ-024 A half access with offset[0]=1, or a word access with offset!=0, SHALL give resp_err=1 with no memory change.
REQ-025 A legal store SHALL write only the addressed byte lanes (SB: 1 lane, SH: 2 lanes, SW: 4 lanes) at the accept edge; all other bytes SHALL be preserved.
REQ-026 A legal load SHALL read the word at the accept edge, shift the addressed lanes down, and then sign-extend (000/001) or zero-extend (100/101).
REQ-027 A load accepted the cycle after a store to the same word SHALL return the newly stored data.
REQ-028 Load data SHALL be registered at accept, so later stores cannot change a pending response.

Reset
REQ-029 While rst is high: all memory words SHALL be 0, resp_valid=0, resp_rdata=0, resp_err=0, and req_ready=1.
REQ-030 Reset asserted with a response pending SHALL discard that response; no response appears after release.
REQ-031 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-032 After reset, LW at 0x10 -> resp_rdata=0x00000000, err=0, resp_valid one cycle after accept.
REQ-033 SW 0x8081F2A3 at 0x20, then LB 0x20, LBU 0x21, LH 0x22, LHU 0x22 -> 0xFFFFFFA3, 0x000000F2, 0xFFFF8081, 0x00008081.
REQ-034 SB 0x5A at 0x23 over 0x8081F2A3, then LW 0x20 -> 0x5A81F2A3.
REQ-035 LH 0x21, SW 0x22, and funct3=011 -> resp_err=1 and resp_rdata=0; a subsequent LW confirms memory is unchanged.
REQ-036 Hold resp_ready=0 for 3 cycles with a request waiting -> req_ready=0, the response holds stable, and the second request is accepted the cycle resp_ready=1.
REQ-037 Assert rst mid-stream with resp_valid=1 -> outputs go to zero immediately (asynchronous), and memory reads back 0 after release.
